tdc_readout_buffer: RTL and testbench
=====================================

# tdc_readout_buffer

Downstream consumer of the TDC_V1_SW_28_10_19 sequencer. Captures the 16-bit words the sequencer emits on its `write` strobe and frames each measurement run as one record: a header plus 8 data words (4 TDCs × 2 words). Records are stored in an on-chip circular buffer and drained by the host-side readout logic. Incomplete records are never exposed to the reader. A back-pressure flag tells run control whether a complete record still fits.

## Interface
- `DEPTH_LOG2`, 9: buffer depth = 2^DEPTH_LOG2 16-bit words; legal range 4..12.
- `WORDS_PER_RUN`, 8: data words expected per record.

- `clk` input 1: clock, shared with the sequencer.
- `reset` input 1: asynchronous, active-high.
- `seq_measure_flag` input 1: sequencer measure flag; a rising edge opens a record.
- `seq_write` input 1: the word on `seq_data` is valid this cycle.
- `seq_data` input 16: sequencer data word.
- `run_allowed` output 1: high when idle and free space ≥ RECORD_LEN; run control gates `run_sequencer` with it.
- `rd_en` input 1: read request.
- `rd_data` output 16: registered read data.
- `rd_valid` output 1: one-cycle pulse; `rd_data` is valid.
- `empty` output 1: no committed words.
- `full` output 1: free space is 0.
- `committed_words` output DEPTH_LOG2+1: committed, unread words.
- `run_count` output 16: records committed since reset; wraps.
- `error_count` output 8: truncated records plus stray words; saturates at 255.
- `overflow` output 1: sticky; a record was dropped for lack of space.
- `clear_overflow` input 1: clears `overflow` and `error_count`.

## Operation
- RECORD_LEN = 1 + WORDS_PER_RUN (+1 with checksum) = 9 by default.
- Pointers are DEPTH_LOG2+1 bits: `rd_ptr`, `commit_ptr`, `wr_ptr` (shadow).
  - `committed_words` = commit_ptr − rd_ptr.
  - free = 2^DEPTH_LOG2 − (wr_ptr − rd_ptr).
- Header word = {4'hA, run_count[11:0]}. run_count is the value before the increment.
- States:
  - **S_IDLE**
    - Measure rising edge with free ≥ RECORD_LEN: write the header at `wr_ptr`, advance `wr_ptr`, clear `word_cnt` → S_COLLECT.
    - Measure rising edge with free < RECORD_LEN: set `overflow` → S_DROP.
    - `seq_write` while idle: stray word, discarded, `error_count`+1.
  - **S_COLLECT**
    - Each `seq_write` stores `seq_data`, advances `wr_ptr`, and increments `word_cnt`.
    - On the 8th word: `commit_ptr` ← new `wr_ptr`, `run_count`+1 → S_IDLE. With checksum enabled → S_TRAILER instead, and the commit is deferred.
    - Measure rising edge before 8 words: rollback `wr_ptr` ← `commit_ptr`, `error_count`+1, then handle the edge as in S_IDLE in the same cycle.
  - **S_TRAILER** (checksum builds only): write the checksum, commit, `run_count`+1 → S_IDLE.
  - **S_DROP**
    - Count `seq_write` words without storing them.
    - After 8 words → S_IDLE.
    - Measure rising edge → handled as in S_IDLE.
- Read: `rd_en` && !empty → `rd_data` ← mem[rd_ptr], `rd_valid`=1 next cycle, `rd_ptr`+1.
  - `rd_en` while empty is ignored: no pulse, `rd_data` holds.
- A simultaneous read and write in the same cycle is legal; both pointers update.
- `run_allowed` = (state == S_IDLE) && free ≥ RECORD_LEN.

## Timing
- Reset values:
  - `rd_data` = 0, `rd_valid` = 0.
  - `empty` = 1, `full` = 0, `committed_words` = 0.
  - `run_count` = 0, `error_count` = 0, `overflow` = 0.
  - `run_allowed` = 1; all pointers 0; state S_IDLE.
- Edge detect: the measure flag is registered once; the rising edge is acted on in the cycle `seq_measure_flag`=1 and flag_d=0.
- Write latency: a word present at edge N is stored at edge N.
- Commit latency: words become visible (`empty`=0) the cycle after the edge that stores the 8th word (checksum builds: the trailer word).
- Read latency: 1 cycle from `rd_en` to `rd_valid`.
- Throughput: 1 write and 1 read per cycle.
- Reset mid-record: the partial record is discarded and all pointers are zeroed.
- Counters:
  - `run_count` wraps 0xFFFF → 0.
  - `error_count` saturates.
  - `clear_overflow` has priority over a same-cycle increment.

## Configuration
- `TDC_READOUT_CHECKSUM_EN` defined:
  - RECORD_LEN = 10.
  - After the 8th data word, a trailer = XOR of the header and all 8 data words is written in S_TRAILER. The commit happens on that edge.
- Not defined:
  - RECORD_LEN = 9; S_TRAILER is absent; commit happens on the 8th data word.

## Test plan
- Single run (data 0x0101..0x0108) → read back 0xA000, then 0x0101..0x0108; `run_count`=1; `empty`=1 afterwards. With checksum: 10th word = 0xA000^0x0008 = 0xA008.
- Three back-to-back runs, no reads → 27 committed words; headers 0xA000, 0xA001, 0xA002.
- Truncation: measure edge, 3 words, second measure edge → partial record invisible; `error_count`=1; next full record has header 0xA000.
- Overflow with DEPTH_LOG2=4 → second run dropped, `overflow`=1, its 8 words not stored; `run_allowed`=0 after the first record.
- Stray `seq_write` in S_IDLE → `error_count`+1, `committed_words` unchanged. `clear_overflow` → flags and counters return to 0.
- Reset asserted after 5 words of a record → all outputs at reset values; first read afterwards gets 0xA000 of the next run.

Source files
------------

// File: rtl/tdc_readout_buffer.sv
// Frames TDC sequencer words into header+data records in a circular buffer; only whole records
// are exposed to the reader. Define TDC_READOUT_CHECKSUM_EN to append an XOR trailer per record.
module tdc_readout_buffer #(
    parameter int unsigned DEPTH_LOG2    = 9,
    parameter int unsigned WORDS_PER_RUN = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  seq_measure_flag,
    input  logic                  seq_write,
    input  logic [15:0]           seq_data,
    output logic                  run_allowed,
    input  logic                  rd_en,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   committed_words,
    output logic [15:0]           run_count,
    output logic [7:0]            error_count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int unsigned PW = DEPTH_LOG2 + 1;
    localparam int unsigned CW = $clog2(WORDS_PER_RUN) + 1;
`ifdef TDC_READOUT_CHECKSUM_EN
    localparam int unsigned RECORD_LEN = WORDS_PER_RUN + 2;
`else
    localparam int unsigned RECORD_LEN = WORDS_PER_RUN + 1;
`endif
    localparam logic [PW-1:0] DepthW   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] RecLenW  = PW'(RECORD_LEN);
    localparam logic [CW-1:0] LastCnt  = CW'(WORDS_PER_RUN - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StTrailer, StDrop} state_e;

    state_e            state_q, state_d;
    logic              flag_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [15:0]       run_count_q;
    logic [7:0]        error_count_q;
    logic              overflow_q;
    logic [15:0]       rd_data_q;
    logic              rd_valid_q;
    logic [15:0]       mem [0:(1 << DEPTH_LOG2) - 1];

    logic              mem_we;
    logic [PW-1:0]     mem_ptr;
    logic [15:0]       mem_wdata;
    logic              run_inc, err_inc, ovf_set;
    logic [PW-1:0]     free_wr, free_commit;
    logic              meas_rise, fits, last_word, do_read;
    logic [15:0]       header;
`ifdef TDC_READOUT_CHECKSUM_EN
    logic [15:0]       csum_q, csum_d;
`endif

    assign meas_rise   = seq_measure_flag & ~flag_q;
    assign free_wr     = DepthW - (wr_ptr_q - rd_ptr_q);
    // A new record always starts at commit_ptr, so its fit is judged after any rollback.
    assign free_commit = DepthW - (commit_ptr_q - rd_ptr_q);
    assign fits        = free_commit >= RecLenW;
    assign last_word   = seq_write && (word_cnt_q == LastCnt);
    assign header      = {4'hA, run_count_q[11:0]};
    assign do_read     = rd_en && !empty;

    assign committed_words = commit_ptr_q - rd_ptr_q;
    assign empty           = (committed_words == '0);
    assign full            = (free_wr == '0);
    assign run_allowed     = (state_q == StIdle) && (free_wr >= RecLenW);
    assign run_count       = run_count_q;
    assign error_count     = error_count_q;
    assign overflow        = overflow_q;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (meas_rise) state_d = fits ? StCollect : StDrop;
            StCollect: begin
                if (meas_rise) begin
                    state_d = fits ? StCollect : StDrop;
                end else if (last_word) begin
`ifdef TDC_READOUT_CHECKSUM_EN
                    state_d = StTrailer;
`else
                    state_d = StIdle;
`endif
                end
            end
            StDrop: begin
                if (meas_rise)      state_d = fits ? StCollect : StDrop;
                else if (last_word) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we       = 1'b0;
        mem_ptr      = wr_ptr_q;
        mem_wdata    = seq_data;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        word_cnt_d   = word_cnt_q;
        run_inc      = 1'b0;
        err_inc      = 1'b0;
        ovf_set      = 1'b0;
`ifdef TDC_READOUT_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        if (meas_rise && (state_q != StTrailer)) begin
            err_inc    = (state_q == StCollect);
            wr_ptr_d   = commit_ptr_q;
            word_cnt_d = '0;
            if (fits) begin
                mem_we    = 1'b1;
                mem_ptr   = commit_ptr_q;
                mem_wdata = header;
                wr_ptr_d  = commit_ptr_q + 1'b1;
`ifdef TDC_READOUT_CHECKSUM_EN
                csum_d    = header;
`endif
            end else begin
                ovf_set = 1'b1;
            end
        end else begin
            case (state_q)
                StIdle: err_inc = seq_write;
                StCollect: begin
                    if (seq_write) begin
                        mem_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
`ifdef TDC_READOUT_CHECKSUM_EN
                        csum_d     = csum_q ^ seq_data;
`else
                        if (last_word) begin
                            commit_ptr_d = wr_ptr_q + 1'b1;
                            run_inc      = 1'b1;
                        end
`endif
                    end
                end
`ifdef TDC_READOUT_CHECKSUM_EN
                StTrailer: begin
                    mem_we       = 1'b1;
                    mem_wdata    = csum_q;
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    commit_ptr_d = wr_ptr_q + 1'b1;
                    run_inc      = 1'b1;
                end
`endif
                StDrop: if (seq_write) word_cnt_d = word_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_ptr[DEPTH_LOG2-1:0]] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q        <= 1'b0;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            word_cnt_q    <= '0;
            run_count_q   <= '0;
            error_count_q <= '0;
            overflow_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
`ifdef TDC_READOUT_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            flag_q       <= seq_measure_flag;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            word_cnt_q   <= word_cnt_d;
`ifdef TDC_READOUT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
            if (run_inc) run_count_q <= run_count_q + 16'd1;
            if (clear_overflow)                       error_count_q <= '0;
            else if (err_inc && error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
            if (clear_overflow) overflow_q <= 1'b0;
            else if (ovf_set)   overflow_q <= 1'b1;
            rd_valid_q <= do_read;
            if (do_read) begin
                rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_readout_buffer.sv
// Scoreboard bench for tdc_readout_buffer: a 512-word instance and a 16-word instance.
module tb_tdc_readout_buffer;

`ifdef TDC_READOUT_CHECKSUM_EN
    localparam int RL = 10;
`else
    localparam int RL = 9;
`endif

    logic clk, reset;
    logic m_flag, m_write, m_rd_en, m_clear;
    logic [15:0] m_data;
    logic m_run_allowed, m_rd_valid, m_empty, m_full, m_overflow;
    logic [15:0] m_rd_data, m_run_count;
    logic [7:0] m_error_count;
    logic [9:0] m_committed;

    logic s_flag, s_write, s_rd_en, s_clear;
    logic [15:0] s_data;
    logic s_run_allowed, s_rd_valid, s_empty, s_full, s_overflow;
    logic [15:0] s_rd_data, s_run_count;
    logic [7:0] s_error_count;
    logic [4:0] s_committed;

    int checks = 0;
    int errors = 0;
    logic [15:0] m_q[$];
    logic [15:0] s_q[$];
    logic [15:0] exp_run [2];
    logic [15:0] m_last;

    tdc_readout_buffer #(.DEPTH_LOG2(9), .WORDS_PER_RUN(8)) u_main (
        .clk(clk), .reset(reset), .seq_measure_flag(m_flag), .seq_write(m_write),
        .seq_data(m_data), .run_allowed(m_run_allowed), .rd_en(m_rd_en), .rd_data(m_rd_data),
        .rd_valid(m_rd_valid), .empty(m_empty), .full(m_full), .committed_words(m_committed),
        .run_count(m_run_count), .error_count(m_error_count), .overflow(m_overflow),
        .clear_overflow(m_clear)
    );

    tdc_readout_buffer #(.DEPTH_LOG2(4), .WORDS_PER_RUN(8)) u_small (
        .clk(clk), .reset(reset), .seq_measure_flag(s_flag), .seq_write(s_write),
        .seq_data(s_data), .run_allowed(s_run_allowed), .rd_en(s_rd_en), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .empty(s_empty), .full(s_full), .committed_words(s_committed),
        .run_count(s_run_count), .error_count(s_error_count), .overflow(s_overflow),
        .clear_overflow(s_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (m_rd_valid) begin
            checks++;
            if (m_q.size() == 0) begin
                errors++;
                $display("FAIL main_rd unexpected rd_valid, data=%h, expected no output", m_rd_data);
            end else begin
                logic [15:0] e;
                e = m_q.pop_front();
                m_last = e;
                if (m_rd_data !== e) begin
                    errors++;
                    $display("FAIL main_rd data=%h expected=%h", m_rd_data, e);
                end
            end
        end
        if (s_rd_valid) begin
            checks++;
            if (s_q.size() == 0) begin
                errors++;
                $display("FAIL small_rd unexpected rd_valid, data=%h, expected no output", s_rd_data);
            end else begin
                logic [15:0] e;
                e = s_q.pop_front();
                if (s_rd_data !== e) begin
                    errors++;
                    $display("FAIL small_rd data=%h expected=%h", s_rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic measure(input int sel);
        if (sel == 0) m_flag = 1'b1; else s_flag = 1'b1;
        tick();
        if (sel == 0) m_flag = 1'b0; else s_flag = 1'b0;
    endtask

    task automatic write_word(input int sel, input logic [15:0] d);
        if (sel == 0) begin m_write = 1'b1; m_data = d; end
        else          begin s_write = 1'b1; s_data = d; end
        tick();
        if (sel == 0) m_write = 1'b0; else s_write = 1'b0;
    endtask

    task automatic push_word(input int sel, input logic [15:0] w);
        if (sel == 0) m_q.push_back(w); else s_q.push_back(w);
    endtask

    // Expected record: header from the model's run counter, data base+1..base+8, optional XOR.
    task automatic push_record(input int sel, input logic [15:0] base);
        logic [15:0] w, cs;
        w = {4'hA, exp_run[sel][11:0]};
        cs = w;
        push_word(sel, w);
        for (int i = 1; i <= 8; i++) begin
            w = base + 16'(i);
            cs = cs ^ w;
            push_word(sel, w);
        end
`ifdef TDC_READOUT_CHECKSUM_EN
        push_word(sel, cs);
`endif
        exp_run[sel] = exp_run[sel] + 16'd1;
    endtask

    task automatic full_run(input int sel, input logic [15:0] base, input bit stored);
        measure(sel);
        for (int i = 1; i <= 8; i++) write_word(sel, base + 16'(i));
`ifdef TDC_READOUT_CHECKSUM_EN
        tick();
`endif
        if (stored) push_record(sel, base);
    endtask

    task automatic drain(input int sel, input int n);
        if (sel == 0) m_rd_en = 1'b1; else s_rd_en = 1'b1;
        repeat (n) tick();
        if (sel == 0) m_rd_en = 1'b0; else s_rd_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_main_reset();
        check("rst_rd_data", 32'(m_rd_data), 32'h0);
        check("rst_rd_valid", 32'(m_rd_valid), 32'h0);
        check("rst_empty", 32'(m_empty), 32'h1);
        check("rst_full", 32'(m_full), 32'h0);
        check("rst_committed", 32'(m_committed), 32'h0);
        check("rst_run_count", 32'(m_run_count), 32'h0);
        check("rst_error_count", 32'(m_error_count), 32'h0);
        check("rst_overflow", 32'(m_overflow), 32'h0);
        check("rst_run_allowed", 32'(m_run_allowed), 32'h1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_q.delete();
        s_q.delete();
        exp_run[0] = '0;
        exp_run[1] = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        {m_flag, m_write, m_rd_en, m_clear, s_flag, s_write, s_rd_en, s_clear} = '0;
        m_data = '0;
        s_data = '0;
        m_last = '0;
        do_reset();
        check_main_reset();
        check("small_rst_run_allowed", 32'(s_run_allowed), 32'h1);

        // Small buffer: second record cannot fit and is dropped.
        full_run(1, 16'h0100, 1'b1);
        check("small_committed_1", 32'(s_committed), 32'(RL));
        check("small_run_allowed_0", 32'(s_run_allowed), 32'h0);
        full_run(1, 16'h0200, 1'b0);
        check("small_overflow", 32'(s_overflow), 32'h1);
        check("small_committed_2", 32'(s_committed), 32'(RL));
        check("small_run_count", 32'(s_run_count), 32'h1);
        check("small_error_count", 32'(s_error_count), 32'h0);
        drain(1, RL);
        check("small_empty", 32'(s_empty), 32'h1);
        check("small_run_allowed_1", 32'(s_run_allowed), 32'h1);
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        check("small_overflow_clr", 32'(s_overflow), 32'h0);

        // Single run with commit-latency check.
        measure(0);
        for (int i = 1; i <= 7; i++) write_word(0, 16'h0100 + 16'(i));
        check("single_empty_before_last", 32'(m_empty), 32'h1);
        full_run_tail();
        check("single_committed", 32'(m_committed), 32'(RL));
        check("single_run_count", 32'(m_run_count), 32'h1);
        check("single_empty_after_commit", 32'(m_empty), 32'h0);
        drain(0, RL);
        check("single_empty_after_read", 32'(m_empty), 32'h1);
        m_rd_en = 1'b1;
        tick();
        m_rd_en = 1'b0;
        check("empty_read_no_valid", 32'(m_rd_valid), 32'h0);
        check("empty_read_data_hold", 32'(m_rd_data), 32'(m_last));

        // Three back-to-back runs, then a read stream overlapping a fourth run.
        do_reset();
        full_run(0, 16'h1000, 1'b1);
        full_run(0, 16'h2000, 1'b1);
        full_run(0, 16'h3000, 1'b1);
        check("three_committed", 32'(m_committed), 32'(3 * RL));
        check("three_run_count", 32'(m_run_count), 32'h3);
        fork
            drain(0, 3 * RL);
            full_run(0, 16'h4000, 1'b1);
        join
        check("overlap_committed", 32'(m_committed), 32'(RL));
        drain(0, RL);
        check("overlap_empty", 32'(m_empty), 32'h1);
        check("overlap_run_count", 32'(m_run_count), 32'h4);

        // Truncated record is rolled back and never exposed.
        do_reset();
        measure(0);
        for (int i = 1; i <= 3; i++) write_word(0, 16'h0E00 + 16'(i));
        check("trunc_empty", 32'(m_empty), 32'h1);
        full_run(0, 16'h0300, 1'b1);
        check("trunc_error_count", 32'(m_error_count), 32'h1);
        check("trunc_committed", 32'(m_committed), 32'(RL));
        check("trunc_run_count", 32'(m_run_count), 32'h1);
        drain(0, RL);

        // Stray words while idle, then clear_overflow winning over a same-cycle stray.
        write_word(0, 16'hDEAD);
        check("stray_error_count", 32'(m_error_count), 32'h2);
        check("stray_committed", 32'(m_committed), 32'h0);
        m_clear = 1'b1;
        write_word(0, 16'hBEEF);
        m_clear = 1'b0;
        check("clear_error_count", 32'(m_error_count), 32'h0);
        check("clear_overflow", 32'(m_overflow), 32'h0);

        // Reset in the middle of a record.
        measure(0);
        for (int i = 1; i <= 5; i++) write_word(0, 16'h0F00 + 16'(i));
        reset = 1'b1;
        #2;
        check_main_reset();
        do_reset();
        full_run(0, 16'h0500, 1'b1);
        drain(0, RL);
        check("post_reset_empty", 32'(m_empty), 32'h1);

        check("main_queue_drained", 32'(m_q.size()), 32'h0);
        check("small_queue_drained", 32'(s_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Completes the single run started inline above: 8th word, optional trailer cycle, model push.
    task automatic full_run_tail();
        write_word(0, 16'h0108);
`ifdef TDC_READOUT_CHECKSUM_EN
        tick();
`endif
        push_record(0, 16'h0100);
    endtask

endmodule
